// File: rtl/calendar_date.sv
// Calendar date counter: day of month, month and year within century.
// Advances on the midnight carry (dayTick), supports parallel load of one field
// with range fixing and date clamping, and exposes the selected field on databus.
// Build option: define CAL_LEAP_YEAR_EN to give February 29 days when year[1:0] == 0.
module calendar_date (
    input  logic       clk,
    input  logic       clear,
    input  logic       dayTick,
    input  logic       load,
    input  logic [1:0] sel,
    input  logic [6:0] data,
    input  logic       enable,
    output logic [4:0] date,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic [6:0] databus,
    output logic       monthCount,
    output logic       yearCount
);

`ifdef CAL_LEAP_YEAR_EN
    localparam logic LeapEn = 1'b1;
`else
    localparam logic LeapEn = 1'b0;
`endif

    localparam logic [1:0] SelDate  = 2'b00;
    localparam logic [1:0] SelMonth = 2'b01;
    localparam logic [1:0] SelYear  = 2'b10;

    // Power-up values match the reset state.
    logic [4:0] date_q = 5'd1;
    logic [3:0] month_q = 4'd1;
    logic [6:0] year_q = 7'd0;
    logic       month_cnt_q = 1'b0;
    logic       year_cnt_q = 1'b0;

    logic [4:0] date_d;
    logic [3:0] month_d;
    logic [6:0] year_d;
    logic       month_cnt_d;
    logic       year_cnt_d;

    logic       load_eff;
    logic [4:0] cur_len;
    logic [4:0] new_len;

    // Days in month m; only the two low year bits matter for the leap rule.
    function automatic logic [4:0] month_len(input logic [3:0] m, input logic [1:0] yl);
        logic [4:0] len;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
            4'd2:                    len = (LeapEn && (yl == 2'b00)) ? 5'd29 : 5'd28;
            default:                 len = 5'd31;
        endcase
        return len;
    endfunction

    // sel == 11 means "no field", so a load there is ignored and a tick still counts.
    assign load_eff = load && (sel != 2'b11);
    assign cur_len  = month_len(month_q, year_q[1:0]);
    assign new_len  = month_len(month_d, year_d[1:0]);

    // Next-state: load has priority over the tick; the tick rolls date -> month -> year.
    always_comb begin
        date_d      = date_q;
        month_d     = month_q;
        year_d      = year_q;
        month_cnt_d = 1'b0;
        year_cnt_d  = 1'b0;
        if (load_eff) begin
            case (sel)
                SelDate: begin
                    if ((data >= 7'd1) && (data <= {2'b00, cur_len})) begin
                        date_d = data[4:0];
                    end else begin
                        date_d = 5'd1;
                    end
                end
                SelMonth: begin
                    if ((data >= 7'd1) && (data <= 7'd12)) begin
                        month_d = data[3:0];
                    end else begin
                        month_d = 4'd1;
                    end
                end
                SelYear: begin
                    if (data <= 7'd99) begin
                        year_d = data;
                    end else begin
                        year_d = 7'd0;
                    end
                end
                default: ;
            endcase
            // A new month or year may shorten the month below the current date.
            if ((sel != SelDate) && (date_q > new_len)) begin
                date_d = new_len;
            end
        end else if (dayTick) begin
            if (date_q < cur_len) begin
                date_d = date_q + 5'd1;
            end else begin
                date_d      = 5'd1;
                month_cnt_d = 1'b1;
                if (month_q == 4'd12) begin
                    month_d    = 4'd1;
                    year_cnt_d = 1'b1;
                    year_d     = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                end else begin
                    month_d = month_q + 4'd1;
                end
            end
        end
    end

    // State registers with synchronous active-low clear overriding everything.
    always_ff @(posedge clk) begin
        if (!clear) begin
            date_q      <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= 7'd0;
            month_cnt_q <= 1'b0;
            year_cnt_q  <= 1'b0;
        end else begin
            date_q      <= date_d;
            month_q     <= month_d;
            year_q      <= year_d;
            month_cnt_q <= month_cnt_d;
            year_cnt_q  <= year_cnt_d;
        end
    end

    // Combinational read-back of the selected field, gated by enable.
    always_comb begin
        databus = 7'd0;
        if (enable) begin
            case (sel)
                SelDate:  databus = {2'b00, date_q};
                SelMonth: databus = {3'b000, month_q};
                SelYear:  databus = year_q;
                default:  databus = 7'd0;
            endcase
        end
    end

    assign date       = date_q;
    assign month      = month_q;
    assign year       = year_q;
    assign monthCount = month_cnt_q;
    assign yearCount  = year_cnt_q;

endmodule

// File: tb/tb_calendar_date.sv
// Randomized self-checking bench for calendar_date: a plain-integer calendar model
// is compared against the DUT on every falling edge, plus literal directed checks.
module tb_calendar_date;

`ifdef CAL_LEAP_YEAR_EN
    localparam bit LEAP = 1'b1;
`else
    localparam bit LEAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       dayTick = 1'b0;
    logic       load = 1'b0;
    logic [1:0] sel = 2'b11;
    logic [6:0] data = 7'd0;
    logic       enable = 1'b1;
    logic [4:0] date;
    logic [3:0] month;
    logic [6:0] year;
    logic [6:0] databus;
    logic       monthCount;
    logic       yearCount;

    int n_vec = 0;
    int n_err = 0;
    bit chk = 1'b0;

    // Model state as plain integers.
    int m_d = 1, m_m = 1, m_y = 0, m_mc = 0, m_yc = 0;

    calendar_date dut (
        .clk        (clk),
        .clear      (clear),
        .dayTick    (dayTick),
        .load       (load),
        .sel        (sel),
        .data       (data),
        .enable     (enable),
        .date       (date),
        .month      (month),
        .year       (year),
        .databus    (databus),
        .monthCount (monthCount),
        .yearCount  (yearCount)
    );

    always #5 clk = ~clk;

    function automatic int mlen(int m, int y);
        if (m == 2) return (LEAP && (y % 4 == 0)) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update for one clock edge, from the inputs present at that edge.
    task automatic model_step(input bit c, input bit l, input int s, input int dv, input bit t);
        m_mc = 0;
        m_yc = 0;
        if (!c) begin
            m_d = 1; m_m = 1; m_y = 0;
        end else if (l && s != 3) begin
            if (s == 0) begin
                m_d = (dv >= 1 && dv <= mlen(m_m, m_y)) ? dv : 1;
            end else begin
                if (s == 1) m_m = (dv >= 1 && dv <= 12) ? dv : 1;
                else        m_y = (dv > 99) ? 0 : dv;
                if (m_d > mlen(m_m, m_y)) m_d = mlen(m_m, m_y);
            end
        end else if (t) begin
            if (m_d < mlen(m_m, m_y)) begin
                m_d++;
            end else begin
                m_d = 1;
                m_mc = 1;
                if (m_m == 12) begin
                    m_m = 1;
                    m_yc = 1;
                    m_y = (m_y + 1) % 100;
                end else begin
                    m_m++;
                end
            end
        end
    endtask

    // Drive inputs, take one edge, advance the model, settle 1 time unit.
    task automatic cyc(input bit c, input bit l, input bit [1:0] s, input bit [6:0] dv,
                       input bit t, input bit e);
        clear = c; load = l; sel = s; data = dv; dayTick = t; enable = e;
        @(posedge clk);
        model_step(c, l, int'(s), int'(dv), t);
        chk = 1'b1;
        #1;
    endtask

    task automatic ld(input bit [1:0] s, input bit [6:0] dv);
        cyc(1'b1, 1'b1, s, dv, 1'b0, 1'b1);
    endtask

    task automatic tick();
        cyc(1'b1, 1'b0, 2'b11, 7'd0, 1'b1, 1'b1);
    endtask

    // Compare process: DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk) begin
            int exp_db;
            check("date", int'(date), m_d);
            check("month", int'(month), m_m);
            check("year", int'(year), m_y);
            check("monthCount", int'(monthCount), m_mc);
            check("yearCount", int'(yearCount), m_yc);
            if (!enable)         exp_db = 0;
            else if (sel == 2'd0) exp_db = m_d;
            else if (sel == 2'd1) exp_db = m_m;
            else if (sel == 2'd2) exp_db = m_y;
            else                  exp_db = 0;
            check("databus", int'(databus), exp_db);
        end
    end

    initial begin
        int hits;
        // Reset.
        cyc(1'b0, 1'b0, 2'b11, 7'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 2'b00, 7'd5, 1'b1, 1'b1);
        check("rst_date", int'(date), 1);
        check("rst_month", int'(month), 1);
        check("rst_year", int'(year), 0);
        check("rst_mc", int'(monthCount), 0);

        // 31 ticks from reset: Feb 1, one monthCount pulse.
        hits = 0;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (monthCount) hits++;
        end
        check("jan_date", int'(date), 1);
        check("jan_month", int'(month), 2);
        check("jan_year", int'(year), 0);
        check("jan_mc_last", int'(monthCount), 1);
        cyc(1'b1, 1'b0, 2'b11, 7'd0, 1'b0, 1'b1);
        if (monthCount) hits++;
        check("jan_mc_once", hits, 1);

        // 31 Dec 98 -> 1 Jan 99.
        ld(2'b10, 7'd98); ld(2'b01, 7'd12); ld(2'b00, 7'd31);
        tick();
        check("y98_date", int'(date), 1);
        check("y98_month", int'(month), 1);
        check("y98_year", int'(year), 99);
        check("y98_yc", int'(yearCount), 1);

        // 31 Dec 99 -> 1 Jan 00.
        ld(2'b10, 7'd99); ld(2'b01, 7'd12); ld(2'b00, 7'd31);
        tick();
        check("y99_year", int'(year), 0);
        check("y99_month", int'(month), 1);
        check("y99_yc", int'(yearCount), 1);

        // 28 Feb 04.
        ld(2'b10, 7'd4); ld(2'b01, 7'd2); ld(2'b00, 7'd28);
        tick();
`ifdef CAL_LEAP_YEAR_EN
        check("leap_date", int'(date), 29);
        check("leap_month", int'(month), 2);
`else
        check("leap_date", int'(date), 1);
        check("leap_month", int'(month), 3);
`endif

        // Clamp on month load, out-of-range date loads.
        ld(2'b01, 7'd3); ld(2'b00, 7'd31); ld(2'b01, 7'd4);
        check("clamp_date", int'(date), 30);
        ld(2'b00, 7'd0);
        check("date0", int'(date), 1);
        ld(2'b00, 7'd40);
        check("date40", int'(date), 1);
        ld(2'b01, 7'd13);
        check("month13", int'(month), 1);
        ld(2'b10, 7'd120);
        check("year120", int'(year), 0);

        // Load beats tick; clear beats load; enable gates databus.
        ld(2'b00, 7'd31);
        cyc(1'b1, 1'b1, 2'b00, 7'd10, 1'b1, 1'b1);
        check("ldtick_date", int'(date), 10);
        check("ldtick_mc", int'(monthCount), 0);
        cyc(1'b1, 1'b0, 2'b00, 7'd0, 1'b0, 1'b0);
        check("en0_bus", int'(databus), 0);
        ld(2'b10, 7'd37);
        sel = 2'b10; enable = 1'b1; #1;
        check("bus_year", int'(databus), 37);
        cyc(1'b0, 1'b1, 2'b10, 7'd55, 1'b0, 1'b1);
        check("clrld_year", int'(year), 0);

        // Clear during a wrap tick suppresses the pulse.
        ld(2'b00, 7'd31);
        cyc(1'b0, 1'b0, 2'b11, 7'd0, 1'b1, 1'b1);
        check("clrwrap_mc", int'(monthCount), 0);
        check("clrwrap_date", int'(date), 1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit c, l, t, e;
            bit [1:0] s;
            bit [6:0] dv;
            c = ($urandom_range(0, 63) != 0);
            l = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 7) != 0);
            s = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       dv = 7'($urandom_range(0, 127));
                1:       dv = 7'd99;
                2:       dv = 7'd12;
                default: dv = 7'($urandom_range(0, 31));
            endcase
            cyc(c, l, s, dv, t, e);
        end

        #20;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
